// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared FSM states, ALU opcodes and error byte for calc_cmd_parser
package calc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GET_A = 3'd1,
    ST_GET_B = 3'd2,
    ST_EXEC  = 3'd3,
    ST_TX_Y  = 3'd4,
    ST_TX_F  = 3'd5,
    ST_ERR   = 3'd6
  } state_e;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_SRA = 4'd7;

  localparam logic [7:0] ERR_BYTE = 8'hEE;

endpackage

// File: rtl/frame_timer.sv
// rtl/frame_timer.sv - inter-byte timeout counter; expired marks LIMIT-1 idle cycles while enabled
module frame_timer #(
  parameter int LIMIT = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (LIMIT > 2) ? $clog2(LIMIT) : 1;

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q + W'(1);
    if (clear || !enable) count_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign expired = enable && (count_q == W'(LIMIT - 1));

endmodule

// File: rtl/calc_cmd_parser.sv
// rtl/calc_cmd_parser.sv - UART byte-frame parser driving an external ALU and returning y and flag bytes
// Optional inter-byte timeout enabled by macro CALC_TIMEOUT_EN.
module calc_cmd_parser
  import calc_pkg::*;
#(
  parameter int N              = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx_valid,
  input  logic [7:0]   rx_data,
  output logic         rx_ready,
  output logic [3:0]   op,
  output logic [N-1:0] a,
  output logic [N-1:0] b,
  input  logic [N-1:0] y,
  input  logic         flg,
  output logic         tx_valid,
  output logic [7:0]   tx_data,
  input  logic         tx_ready,
  output logic         busy,
  output logic         ovr
);

  state_e       state_q, state_d;
  logic [3:0]   op_q, op_d;
  logic [N-1:0] a_q, a_d, b_q, b_d, y_q, y_d;
  logic         flg_q, flg_d, ovr_q, ovr_d;
  logic         rx_open, accept, tx_live, timeout;
  logic [7:0]   tx_byte;

  assign rx_open = (state_q == ST_IDLE) || (state_q == ST_GET_A) || (state_q == ST_GET_B);
  assign accept  = rx_valid && rx_open;
  assign tx_live = (state_q == ST_TX_Y) || (state_q == ST_TX_F) || (state_q == ST_ERR);

`ifdef CALC_TIMEOUT_EN
  frame_timer #(.LIMIT(TIMEOUT_CYCLES)) u_frame_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .enable  ((state_q == ST_GET_A) || (state_q == ST_GET_B)),
    .expired (timeout)
  );
`else
  // Without the timer the parameter is inert; this is constant false for any legal value.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    y_d     = y_q;
    flg_d   = flg_q;
    ovr_d   = ovr_q || (rx_valid && !rx_open);
    tx_byte = 8'h00;
    case (state_q)
      ST_IDLE: if (accept) begin
        if (rx_data[7:3] == 5'd0) begin
          op_d    = rx_data[3:0];
          state_d = ST_GET_A;
        end else begin
          state_d = ST_ERR;
        end
      end
      ST_GET_A: begin
        if (accept) begin
          a_d     = rx_data;
          state_d = ST_GET_B;
        end else if (timeout) state_d = ST_ERR;
      end
      ST_GET_B: begin
        if (accept) begin
          b_d     = rx_data;
          state_d = ST_EXEC;
        end else if (timeout) state_d = ST_ERR;
      end
      ST_EXEC: begin
        y_d     = y;
        flg_d   = flg;
        state_d = ST_TX_Y;
      end
      ST_TX_Y: begin
        tx_byte = y_q;
        if (tx_ready) state_d = ST_TX_F;
      end
      ST_TX_F: begin
        tx_byte = {7'b0, flg_q};
        if (tx_ready) state_d = ST_IDLE;
      end
      ST_ERR: begin
        tx_byte = ERR_BYTE;
        if (tx_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
      flg_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      y_q     <= y_d;
      flg_q   <= flg_d;
      ovr_q   <= ovr_d;
    end
  end

  // Outputs are masked by rst so they show reset values during the reset cycle itself.
  assign rx_ready = rst || rx_open;
  assign tx_valid = !rst && tx_live;
  assign tx_data  = rst ? 8'h00 : tx_byte;
  assign busy     = !rst && (state_q != ST_IDLE);
  assign ovr      = !rst && ovr_q;
  assign op       = rst ? 4'h0 : op_q;
  assign a        = rst ? '0 : a_q;
  assign b        = rst ? '0 : b_q;

endmodule

// File: tb/tb_calc_cmd_parser.sv
// tb/tb_calc_cmd_parser.sv - randomized self-checking bench for calc_cmd_parser with an ALU reference
module tb_calc_cmd_parser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_ready;
  logic [3:0] op;
  logic [7:0] a, b, y;
  logic       flg;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready = 1'b1;
  logic       busy, ovr;

  int total = 0;
  int bad = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  calc_cmd_parser #(.N(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .op(op), .a(a), .b(b), .y(y), .flg(flg),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .busy(busy), .ovr(ovr)
  );

  function automatic logic [7:0] alu_y(input logic [3:0] o, input logic [7:0] x, input logic [7:0] z);
    case (o)
      4'd0: return x + z;
      4'd1: return x - z;
      4'd2: return x & z;
      4'd3: return x | z;
      4'd4: return x ^ z;
      4'd5: return x << z[2:0];
      4'd6: return x >> z[2:0];
      4'd7: return 8'($signed(x) >>> z[2:0]);
      default: return 8'h00;
    endcase
  endfunction

  assign y   = alu_y(op, a, b);
  assign flg = (y == 8'h00);

  always @(negedge clk) if (tx_valid && tx_ready) got_q.push_back(tx_data);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] v);
    rx_data  = v;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic expect_frame(input logic [7:0] o, input logic [7:0] x, input logic [7:0] z);
    if (o[7:3] != 5'd0) begin
      exp_q.push_back(8'hEE);
    end else begin
      exp_q.push_back(alu_y(o[3:0], x, z));
      exp_q.push_back({7'b0, alu_y(o[3:0], x, z) == 8'h00});
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL reset_rx_ready got=%b want=1", rx_ready); end
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%b want=0", tx_valid); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got=%h want=00", tx_data); end
    total++; if ({op, a, b} !== 20'h0) begin bad++; $display("FAIL reset_op_a_b got=%h want=00000", {op, a, b}); end
    total++; if ({busy, ovr} !== 2'b00) begin bad++; $display("FAIL reset_busy_ovr got=%b want=00", {busy, ovr}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_add_latency();
    got_q.delete(); exp_q.delete();
    tx_ready = 1'b1;
    exp_q.push_back(8'h08); exp_q.push_back(8'h00);
    send_byte(8'h00);
    send_byte(8'h05);
    send_byte(8'h03);
    total++; if ({tx_valid, busy} !== 2'b01) begin bad++; $display("FAIL exec_cycle tx_valid,busy got=%b want=01", {tx_valid, busy}); end
    tick();
    total++; if ({tx_valid, tx_data} !== 9'h108) begin bad++; $display("FAIL tx_y_latency got=%h want=108", {tx_valid, tx_data}); end
    tick();
    total++; if ({tx_valid, tx_data} !== 9'h100) begin bad++; $display("FAIL tx_f_byte got=%h want=100", {tx_valid, tx_data}); end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_after_flag got=%b want=0", busy); end
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL add_tx_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL add_tx[%0d] got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_sub_and_error();
    bit ok;
    got_q.delete(); exp_q.delete();
    tx_ready = 1'b1;
    exp_q = '{8'h00, 8'h01, 8'hEE, 8'h30, 8'h00};
    send_byte(8'h01); send_byte(8'h07); send_byte(8'h07);
    wait_idle(20, ok);
    total++; if (!ok) begin bad++; $display("FAIL sub_idle_timeout got=busy want=idle"); end
    send_byte(8'h1A);
    wait_idle(20, ok);
    total++; if (!ok) begin bad++; $display("FAIL err_idle_timeout got=busy want=idle"); end
    send_byte(8'h02); send_byte(8'hF0); send_byte(8'h3C);
    wait_idle(20, ok);
    total++; if (!ok) begin bad++; $display("FAIL and_idle_timeout got=busy want=idle"); end
    total++; if (ovr !== 1'b0) begin bad++; $display("FAIL err_no_ovr got=%b want=0", ovr); end
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL suberr_tx_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL suberr_tx[%0d] got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    got_q.delete(); exp_q.delete();
    tx_ready = 1'b0;
    expect_frame(8'h00, 8'h20, 8'h11);
    send_byte(8'h00); send_byte(8'h20); send_byte(8'h11);
    tick();
    total++; if (ovr !== 1'b0) begin bad++; $display("FAIL ovr_before_pulse got=%b want=0", ovr); end
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin rx_data = 8'h55; rx_valid = 1'b1; end
      tick();
      rx_valid = 1'b0;
      total++; if ({tx_valid, tx_data} !== 9'h131) begin bad++; $display("FAIL stall_hold[%0d] got=%h want=131", i, {tx_valid, tx_data}); end
    end
    total++; if (ovr !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b want=1", ovr); end
    tx_ready = 1'b1;
    tick(); tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL stall_end_busy got=%b want=0", busy); end
    total++; if (ovr !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b want=1", ovr); end
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL stall_tx_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL stall_tx[%0d] got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_mid_frame_reset();
    bit ok;
    got_q.delete(); exp_q.delete();
    tx_ready = 1'b1;
    send_byte(8'h00); send_byte(8'h05);
    rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b1;
    tick();
    total++; if ({rx_ready, tx_valid, busy, ovr} !== 4'b1000) begin bad++; $display("FAIL rst_flags got=%b want=1000", {rx_ready, tx_valid, busy, ovr}); end
    total++; if ({op, a, b, tx_data} !== 28'h0) begin bad++; $display("FAIL rst_data got=%h want=0000000", {op, a, b, tx_data}); end
    rst = 1'b0; rx_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_byte_ignored busy got=%b want=0", busy); end
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL rst_no_tx got=%0d want=0", got_q.size()); end
    exp_q = '{8'h02, 8'h00};
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h01);
    wait_idle(20, ok);
    total++; if (!ok) begin bad++; $display("FAIL post_rst_idle got=busy want=idle"); end
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL post_rst_tx_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL post_rst_tx[%0d] got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] o, x, z;
    got_q.delete(); exp_q.delete();
    tx_ready = 1'b1;
    for (int f = 0; f < 6; f++) begin
      o = 8'($urandom_range(0, 7)); x = 8'($urandom); z = 8'($urandom);
      expect_frame(o, x, z);
      send_byte(o); send_byte(x); send_byte(z);
      tick(); tick(); tick();
      total++; if ({rx_ready, busy} !== 2'b10) begin bad++; $display("FAIL b2b_ready[%0d] got=%b want=10", f, {rx_ready, busy}); end
    end
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL b2b_tx_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_tx[%0d] got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    logic [7:0] o, x, z;
    int n;
    got_q.delete(); exp_q.delete();
    rst = 1'b1; tick(); rst = 1'b0; tick();
    for (int f = 0; f < 25; f++) begin
      o = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(8, 255)) : 8'($urandom_range(0, 7));
      x = 8'($urandom); z = 8'($urandom);
      expect_frame(o, x, z);
      send_byte(o);
      if (o[7:3] == 5'd0) begin send_byte(x); send_byte(z); end
      n = 0;
      while (busy && n < 100) begin
        tx_ready = 1'($urandom);
        tick();
        n++;
      end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rand_idle_timeout[%0d] got=busy want=idle", f); end
    end
    tx_ready = 1'b1;
    total++; if (ovr !== 1'b0) begin bad++; $display("FAIL rand_ovr got=%b want=0", ovr); end
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rand_tx_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_tx[%0d] got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_timeout();
    got_q.delete(); exp_q.delete();
    tx_ready = 1'b1;
    send_byte(8'h03);
`ifdef CALC_TIMEOUT_EN
    exp_q.push_back(8'hEE);
    for (int i = 0; i < 20; i++) tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL timeout_idle got=%b want=0", busy); end
`else
    for (int i = 0; i < 30; i++) tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL wait_forever busy got=%b want=1", busy); end
    expect_frame(8'h03, 8'h0C, 8'h30);
    send_byte(8'h0C); send_byte(8'h30);
    tick(); tick(); tick();
`endif
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL timeout_tx_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL timeout_tx[%0d] got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_add_latency();
    test_sub_and_error();
    test_backpressure();
    test_mid_frame_reset();
    test_back_to_back();
    test_random();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/calc_cmd_parser.md
CALC_CMD_PARSER -- requirements
Module: calc_cmd_parser

Interface
REQ-001 SHALL have parameter N, default 8: operand/result width; only N=8 is supported.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100000: inter-byte timeout limit in clk cycles.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port rx_valid, input, 1: UART RX byte strobe, one cycle per byte.
REQ-006 SHALL have port rx_data, input, 8: received byte.
REQ-007 SHALL have port rx_ready, output, 1: high when a byte can be accepted.
REQ-008 SHALL have port op, output, 4: opcode to the ALU.
REQ-009 SHALL have port a, output, N: first operand to the ALU.
REQ-010 SHALL have port b, output, N: second operand to the ALU.
REQ-011 SHALL have port y, input, N: combinational ALU result.
REQ-012 SHALL have port flg, input, 1: combinational ALU zero/compare flag.
REQ-013 SHALL have port tx_valid, output, 1: byte is offered to UART TX.
REQ-014 SHALL have port tx_data, output, 8: byte to transmit.
REQ-015 SHALL have port tx_ready, input, 1: UART TX accepts the byte.
REQ-016 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-017 SHALL have port ovr, output, 1: sticky overrun flag.

Function
REQ-018 SHALL implement the FSM IDLE -> GET_A -> GET_B -> EXEC -> TX_Y -> TX_F -> IDLE, plus an ERR state.
REQ-019 In IDLE, a byte is accepted when rx_valid=1 and rx_ready=1.
REQ-020 In IDLE, if rx_data[7:3]==0, the parser SHALL register op=rx_data[3:0] and go to GET_A; otherwise it SHALL go to ERR.
REQ-021 In GET_A, an accepted byte SHALL register into a and the FSM SHALL go to GET_B.
REQ-022 In GET_B, an accepted byte SHALL register into b and the FSM SHALL go to EXEC.
REQ-023 rx_ready SHALL be 1 only in IDLE, GET_A and GET_B.
REQ-024 An rx_valid pulse while rx_ready=0 SHALL drop the byte and set ovr=1; ovr stays set until reset.
REQ-025 EXEC SHALL last exactly one cycle, latching y and flg into internal registers, then go to TX_Y.
REQ-026 op, a and b SHALL hold stable from their capture until the next frame's opcode capture.
REQ-027 In TX_Y, the parser SHALL drive tx_valid=1 and tx_data = latched y.
REQ-028 In TX_F, the parser SHALL drive tx_valid=1 and tx_data = {7'b0, latched flg}.
REQ-029 In ERR, the parser SHALL drive tx_valid=1 and tx_data = ERR_BYTE (8'hEE).
REQ-030 Each TX state SHALL advance only on the cycle where tx_valid && tx_ready; tx_data SHALL be stable while tx_valid=1 and tx_ready=0.
REQ-031 The TX successor states SHALL be: TX_Y -> TX_F, TX_F -> IDLE, ERR -> IDLE.
REQ-032 tx_valid SHALL be 0 in IDLE, GET_A, GET_B and EXEC.
REQ-033 Latency SHALL be: the b byte is accepted in cycle t, EXEC occurs in t+1, and tx_valid rises in t+2.
REQ-034 Back-to-back frames SHALL be supported: an opcode byte is accepted in the cycle immediately after TX_F completes.

Reset
REQ-035 While rst=1, the parser SHALL force state=IDLE, op=0, a=0, b=0, tx_valid=0, tx_data=0, ovr=0, busy=0 and rx_ready=1.
REQ-036 Reset asserted mid-frame or mid-transmit SHALL abandon the frame with no further TX byte; a byte presented in the reset cycle is ignored.

Configuration
REQ-037 With macro CALC_TIMEOUT_EN defined, the parser SHALL run a cycle counter in GET_A and GET_B that clears on each accepted byte.
REQ-038 With CALC_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES-1 without a byte SHALL send the FSM to ERR.
REQ-039 With CALC_TIMEOUT_EN undefined, no counter SHALL exist and GET_A and GET_B SHALL wait indefinitely.

Structure
REQ-040 Package calc_pkg SHALL hold the FSM state enum, the opcode constants OP_ADD through OP_SRA (0-7), and ERR_BYTE.
REQ-041 The timeout counter SHALL be the sub-module frame_timer (inputs clear, enable; output expired), instantiated only under CALC_TIMEOUT_EN.

Verification
REQ-042 Bytes 0x00, 0x05, 0x03 with the ALU connected and tx_ready=1 SHALL produce TX 0x08 then 0x00; busy SHALL fall after the second byte.
REQ-043 Bytes 0x01, 0x07, 0x07 SHALL produce TX 0x00 then 0x01.
REQ-044 Opcode byte 0x1A SHALL produce TX 0xEE, after which the next frame 0x02, 0xF0, 0x3C SHALL produce TX 0x30 then 0x00.
REQ-045 With tx_ready held 0 for 10 cycles in TX_Y, tx_data SHALL stay at the y value, and an rx_valid pulse in that window SHALL set ovr=1 and leave TX bytes unchanged.
REQ-046 With rst pulsed after byte 0x05 in GET_B, no TX SHALL occur, all outputs SHALL equal reset values, and the frame 0x00, 0x01, 0x01 SHALL produce TX 0x02 then 0x00.
REQ-047 With CALC_TIMEOUT_EN and TIMEOUT_CYCLES=16, an opcode byte followed by 20 idle cycles SHALL produce TX 0xEE, and the FSM SHALL return to IDLE.
